// File: rtl/ioctl_mem_loader.sv
// ioctl download/upload bridge: packs download bytes into 16-bit words, buffers them
// in a small FIFO and drains them to a word-wide req/ack memory port; serves upload reads.
module ioctl_mem_loader #(
  parameter logic [23:0] BASE_ADDR   = 24'd0,
  parameter logic [7:0]  INDEX_MASK  = 8'hFF,
  parameter logic [7:0]  INDEX_VALUE = 8'h00,
  parameter int          FIFO_DEPTH  = 4,
  parameter bit          BIG_ENDIAN  = 1'b0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_din,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [23:0] waddr;
    logic [15:0] data;
    logic [1:0]  be;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR      = 2'd1,
    S_RD_REQ  = 2'd2,
    S_RD_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        dl_q, ul_q;
  logic        pend_v_q, pend_v_d;
  entry_t      pend_q, pend_d;
  logic        ovf_q, ovf_d;
  entry_t      fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic        mem_req_q, mem_we_q;
  logic [23:0] mem_addr_q;
  logic [1:0]  mem_be_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] rword_q;
  logic [23:0] rtag_q, rd_tag_q;
  logic        rvalid_q;
  logic [7:0]  din_q;

  logic        sel_s, dl_rise_s, dl_fall_s, ul_rise_s, acc_s, lane_s;
  logic        pend_live_s, full_s, pop_s, push_s, clear_fifo_s, rd_need_s;
  entry_t      push_e_s, new_e_s, head_s;
  logic [15:0] merged_data_s;
  logic [1:0]  merged_be_s;

  assign sel_s     = ((ioctl_index & INDEX_MASK) == (INDEX_VALUE & INDEX_MASK));
  assign dl_rise_s = ioctl_download && !dl_q;
  assign dl_fall_s = !ioctl_download && dl_q;
  assign ul_rise_s = ioctl_upload && !ul_q;
  assign acc_s     = ioctl_wr && ioctl_download && sel_s;
  assign lane_s    = ioctl_addr[0] ^ BIG_ENDIAN;
  assign full_s    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_s     = (state_q == S_IDLE) && (cnt_q != {CW{1'b0}});
  assign head_s    = fifo_mem_q[rd_ptr_q];
  assign rd_need_s = ioctl_upload && sel_s && !ioctl_download &&
                     (!rvalid_q || (rtag_q != ioctl_addr[24:1]));

  assign new_e_s.waddr  = ioctl_addr[24:1];
  assign new_e_s.data   = lane_s ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
  assign new_e_s.be     = lane_s ? 2'b10 : 2'b01;
  assign merged_data_s  = lane_s ? {ioctl_dout, pend_q.data[7:0]} : {pend_q.data[15:8], ioctl_dout};
  assign merged_be_s    = pend_q.be | new_e_s.be;

  // Byte packing into the pending word and FIFO push / overflow decisions.
  always_comb begin
    pend_v_d     = pend_v_q;
    pend_d       = pend_q;
    ovf_d        = ovf_q;
    push_s       = 1'b0;
    push_e_s     = pend_q;
    clear_fifo_s = 1'b0;
    pend_live_s  = pend_v_q;
    if (dl_rise_s && sel_s) begin
      pend_v_d     = 1'b0;
      pend_live_s  = 1'b0;
      ovf_d        = 1'b0;
      clear_fifo_s = 1'b1;
    end else begin
      pend_live_s  = pend_v_q;
    end
    if (acc_s) begin
      if (!pend_live_s) begin
        pend_v_d = 1'b1;
        pend_d   = new_e_s;
      end else if (pend_q.waddr == ioctl_addr[24:1]) begin
        pend_d.data = merged_data_s;
        pend_d.be   = merged_be_s;
        if (merged_be_s == 2'b11) begin
          push_s         = 1'b1;
          push_e_s.waddr = pend_q.waddr;
          push_e_s.data  = merged_data_s;
          push_e_s.be    = merged_be_s;
          pend_v_d       = 1'b0;
        end else begin
          pend_v_d = 1'b1;
        end
      end else begin
        push_s   = 1'b1;
        pend_v_d = 1'b1;
        pend_d   = new_e_s;
      end
    end else if (dl_fall_s && pend_v_q) begin
      push_s   = 1'b1;
      pend_v_d = 1'b0;
    end else begin
      push_s = 1'b0;
    end
    // A full FIFO loses both the word being pushed and whatever byte caused it.
    if (push_s && full_s && !pop_s) begin
      push_s   = 1'b0;
      pend_v_d = 1'b0;
      ovf_d    = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // Pending word, edge detectors, sticky overflow and busy.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      dl_q     <= 1'b0;
      ul_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      dl_q     <= ioctl_download;
      ul_q     <= ioctl_upload;
      busy_q   <= (ioctl_download && sel_s) || pend_v_q || (cnt_q != {CW{1'b0}}) || mem_req_q;
    end
  end

  // Word FIFO storage and pointers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else if (clear_fifo_s) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= push_e_s;
        wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      if (push_s && !pop_s) cnt_q <= cnt_q + CW'(1);
      else if (pop_s && !push_s) cnt_q <= cnt_q - CW'(1);
      else cnt_q <= cnt_q;
    end
  end

  // Memory port FSM, read cache and upload byte.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 24'd0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= 16'd0;
      rword_q     <= 16'd0;
      rtag_q      <= 24'd0;
      rd_tag_q    <= 24'd0;
      rvalid_q    <= 1'b0;
      din_q       <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= BASE_ADDR + head_s.waddr;
            mem_be_q    <= head_s.be;
            mem_wdata_q <= head_s.data;
            if (head_s.waddr == rtag_q) rvalid_q <= 1'b0;
            state_q     <= S_WR;
          end else if (rd_need_s) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 2'b11;
            mem_addr_q <= BASE_ADDR + ioctl_addr[24:1];
            rd_tag_q   <= ioctl_addr[24:1];
            state_q    <= S_RD_REQ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            state_q <= S_WR;
          end
        end
        S_RD_REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            rword_q   <= mem_rdata;
            rtag_q    <= rd_tag_q;
            rvalid_q  <= 1'b1;
            state_q   <= S_RD_DONE;
          end else begin
            state_q <= S_RD_REQ;
          end
        end
        S_RD_DONE: state_q <= S_IDLE;
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
      if (ul_rise_s) rvalid_q <= 1'b0;
      if (rvalid_q && (rtag_q == ioctl_addr[24:1])) begin
        din_q <= lane_s ? rword_q[15:8] : rword_q[7:0];
      end else begin
        din_q <= din_q;
      end
    end
  end

  assign ioctl_din = din_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ioctl_mem_loader.sv
// Scoreboard bench: stimulus pushes expected memory requests, a monitor pops and compares.
module tb_ioctl_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_upload, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout, ioctl_din;
  logic [24:0] ioctl_addr;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, overflow;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } req_t;

  req_t        sb_q [$];
  logic [15:0] mem_model [int];
  int          n_run = 0;
  int          n_fail = 0;
  logic        hold = 1'b0;
  logic        late_ack = 1'b0;
  logic        ack_given = 1'b0;
  logic        req_seen = 1'b0;
  int          wait_cnt = 0;

  ioctl_mem_loader #(
    .BASE_ADDR(24'h000100), .INDEX_MASK(8'hFF), .INDEX_VALUE(8'h00),
    .FIFO_DEPTH(4), .BIG_ENDIAN(1'b0)
  ) dut (
    .clk_sys(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input logic we, input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    req_t r;
    r.we = we; r.addr = a; r.data = d; r.be = be;
    sb_q.push_back(r);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick(); tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || mem_req || sb_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check(name, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Memory responder: acks each request after a short delay unless held off.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack = 1'b1;
        late_ack = 1'b0;
      end else if (!mem_req) begin
        ack_given = 1'b0;
        wait_cnt = 0;
      end else if (!ack_given && !hold) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          mem_ack = 1'b1;
          ack_given = 1'b1;
          if (mem_we) begin
            logic [15:0] w;
            w = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 16'h0000;
            if (mem_be[0]) w[7:0] = mem_wdata[7:0];
            if (mem_be[1]) w[15:8] = mem_wdata[15:8];
            mem_model[int'(mem_addr)] = w;
          end else begin
            mem_rdata = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 16'h0000;
          end
        end
      end
    end
  end

  // Monitor: every new request is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        req_seen = 1'b0;
      end else if (!req_seen) begin
        req_seen = 1'b1;
        if (sb_q.size() == 0) begin
          check("unexpected_req_addr", {8'h00, mem_addr}, 32'hFFFFFFFF);
        end else begin
          req_t r;
          r = sb_q.pop_front();
          check("req_we", {31'd0, mem_we}, {31'd0, r.we});
          check("req_addr", {8'h00, mem_addr}, {8'h00, r.addr});
          if (r.we) begin
            check("req_wdata", {16'h0000, mem_wdata}, {16'h0000, r.data});
            check("req_be", {30'd0, mem_be}, {30'd0, r.be});
          end else begin
            check("req_rd_be", {30'd0, mem_be}, 32'd3);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'h00; ioctl_addr = 25'd0; ioctl_dout = 8'h00;
    tick(); tick(); tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {8'h00, mem_addr}, 32'd0);
    check("rst_mem_be_wdata", {14'd0, mem_be, mem_wdata}, 32'd0);
    check("rst_din_busy_ovf", {22'd0, ioctl_din, busy, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Full words at consecutive addresses.
    exp_req(1'b1, 24'h100, 16'hBBAA, 2'b11);
    exp_req(1'b1, 24'h101, 16'hDDCC, 2'b11);
    ioctl_download = 1'b1; tick();
    check("busy_dl", {31'd0, busy}, 32'd1);
    wr_byte(25'd0, 8'hAA); wr_byte(25'd1, 8'hBB);
    wr_byte(25'd2, 8'hCC); wr_byte(25'd3, 8'hDD);
    ioctl_download = 1'b0;
    wait_idle("t1_idle");
    tick();
    check("t1_busy_low", {31'd0, busy}, 32'd0);

    // Partial last word flushed on download end.
    exp_req(1'b1, 24'h100, 16'hBBAA, 2'b11);
    exp_req(1'b1, 24'h101, 16'h00CC, 2'b01);
    ioctl_download = 1'b1; tick();
    wr_byte(25'd0, 8'hAA); wr_byte(25'd1, 8'hBB); wr_byte(25'd2, 8'hCC);
    ioctl_download = 1'b0;
    wait_idle("t2_idle");

    // Address jump: odd byte at word 2, even byte at word 4.
    exp_req(1'b1, 24'h102, 16'h5500, 2'b10);
    exp_req(1'b1, 24'h104, 16'h0088, 2'b01);
    ioctl_download = 1'b1; tick();
    wr_byte(25'd5, 8'h55); wr_byte(25'd8, 8'h88);
    ioctl_download = 1'b0;
    wait_idle("t3_idle");

    // Overflow: acks held off while 6 words arrive; the 6th is dropped.
    for (int w = 0; w < 5; w++)
      exp_req(1'b1, 24'h100 + 24'(w), {8'(8'h11 + 8'(2 * w)), 8'(8'h10 + 8'(2 * w))}, 2'b11);
    hold = 1'b1;
    ioctl_download = 1'b1; tick();
    for (int i = 0; i < 12; i++) wr_byte(25'(i), 8'(8'h10 + 8'(i)));
    check("t4_overflow_set", {31'd0, overflow}, 32'd1);
    hold = 1'b0;
    ioctl_download = 1'b0;
    wait_idle("t4_idle");
    check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);
    ioctl_download = 1'b1; tick(); tick();
    check("t4_overflow_cleared", {31'd0, overflow}, 32'd0);
    ioctl_download = 1'b0;
    wait_idle("t4b_idle");

    // Upload: one read serves both bytes of the word.
    mem_model[24'h100] = 16'h1234;
    exp_req(1'b0, 24'h100, 16'h0000, 2'b11);
    ioctl_addr = 25'd0; ioctl_upload = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t5_din_lo", {24'd0, ioctl_din}, 32'h34);
    ioctl_addr = 25'd1;
    for (int i = 0; i < 6; i++) tick();
    check("t5_din_hi", {24'd0, ioctl_din}, 32'h12);
    check("t5_sb_empty", sb_q.size(), 32'd0);
    ioctl_upload = 1'b0;
    tick();

    // Reset in the middle of a held write; a late ack must do nothing.
    exp_req(1'b1, 24'h100, 16'hBBAA, 2'b11);
    hold = 1'b1;
    ioctl_download = 1'b1; tick();
    wr_byte(25'd0, 8'hAA); wr_byte(25'd1, 8'hBB);
    begin
      int n = 0;
      while (!mem_req && n < 50) begin tick(); n++; end
      check("t6_req_seen", {31'd0, mem_req}, 32'd1);
    end
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    check("t6_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    check("t6_rst_outputs", {13'd0, mem_we, mem_be, mem_wdata}, 32'd0);
    check("t6_rst_addr", {8'h00, mem_addr}, 32'd0);
    check("t6_rst_flags", {22'd0, ioctl_din, busy, overflow}, 32'd0);
    reset = 1'b0; hold = 1'b0;
    tick();
    late_ack = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t6_late_ack_req", {30'd0, mem_req, mem_we}, 32'd0);
    check("t6_late_ack_busy", {31'd0, busy}, 32'd0);
    check("final_sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
